// File: rtl/npu_act_pkg.sv
// Shared encodings and constants for the linear-activation producer stage.
package npu_act_pkg;

    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned COE_BASE = 0;
    localparam logic [7:0]  MAX_RST  = 8'h7F;
    localparam logic [7:0]  MIN_RST  = 8'h80;

    // Address-map helpers; the map scales with the segment count
    function automatic int unsigned bp_base(input int unsigned nseg);
        return nseg;
    endfunction

    function automatic int unsigned max_addr(input int unsigned nseg);
        return 2 * nseg - 1;
    endfunction

    function automatic int unsigned min_addr(input int unsigned nseg);
        return 2 * nseg;
    endfunction

endpackage

// File: rtl/act_seg_cmp.sv
// Breakpoint comparator: segment index is the number of breakpoints the sample meets or exceeds.
module act_seg_cmp #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NSEG       = 8,
    parameter int unsigned SEG_W      = 3
) (
    input  logic [DATA_WIDTH-1:0]          i_dat,
    input  logic [(NSEG-1)*DATA_WIDTH-1:0] i_bp,
    output logic [SEG_W-1:0]               o_seg_c
);

    // Counting rather than priority-encoding keeps the index in range for any table order
    always_comb begin
        o_seg_c = '0;
        for (int k = 0; k < NSEG - 1; k++) begin
            if ($signed(i_dat) >= $signed(i_bp[k*DATA_WIDTH +: DATA_WIDTH])) begin
                o_seg_c = o_seg_c + SEG_W'(1);
            end
        end
    end

endmodule

// File: rtl/act_seg_sel.sv
// Producer side of the piecewise-linear activation: segment select, clamp flags, coefficient lookup.
// Optional register readback port enabled by defining ACT_SEG_SEL_READBACK_EN.
module act_seg_sel
    import npu_act_pkg::*;
#(
    parameter int unsigned COE_A_WIDTH = 8,
    parameter int unsigned COE_B_WIDTH = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NSEG        = 8,
    parameter int unsigned ADDR_WIDTH  = 5
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic                               i_stop,
    input  logic                               i_cfg_we,
    input  logic [ADDR_WIDTH-1:0]              i_cfg_addr,
    input  logic [COE_A_WIDTH+COE_B_WIDTH-1:0] i_cfg_wdata,
    output logic                               o_cfg_err,
`ifdef ACT_SEG_SEL_READBACK_EN
    input  logic                               i_cfg_re,
    output logic [COE_A_WIDTH+COE_B_WIDTH-1:0] o_cfg_rdata,
`endif
    input  logic                               i_valid,
    output logic                               o_in_ready,
    input  logic [DATA_WIDTH-1:0]              i_dat,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [DATA_WIDTH-1:0]              o_dat,
    output logic [COE_A_WIDTH+COE_B_WIDTH-1:0] o_act_coe,
    output logic                               o_max_value_en,
    output logic                               o_min_value_en,
    output logic [DATA_WIDTH-1:0]              o_max_value,
    output logic [DATA_WIDTH-1:0]              o_min_value,
    output logic [1:0]                         o_state
);

    localparam int unsigned COE_W = COE_A_WIDTH + COE_B_WIDTH;
    localparam int unsigned SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int unsigned NBP   = NSEG - 1;
    localparam int unsigned A_BP  = bp_base(NSEG);
    localparam int unsigned A_MAX = max_addr(NSEG);
    localparam int unsigned A_MIN = min_addr(NSEG);

    state_t                      r_state;
    logic [COE_W-1:0]            r_coe [NSEG];
    logic [NBP*DATA_WIDTH-1:0]   r_bp;
    logic [DATA_WIDTH-1:0]       r_max;
    logic [DATA_WIDTH-1:0]       r_min;
    logic                        r_cfg_err;

    logic                        r_s1_valid;
    logic [DATA_WIDTH-1:0]       r_s1_dat;
    logic [SEG_W-1:0]            r_s1_seg;
    logic                        r_s1_max_en;
    logic                        r_s1_min_en;

    logic                        r_s2_valid;
    logic [DATA_WIDTH-1:0]       r_s2_dat;
    logic [COE_W-1:0]            r_s2_coe;
    logic                        r_s2_max_en;
    logic                        r_s2_min_en;

    logic                        w_en;
    logic                        w_accept;
    logic                        w_addr_ok;
    logic                        w_wr_ok;
    logic                        w_wr_err;
    logic                        w_rd_err;
    logic [SEG_W-1:0]            w_seg;
    logic                        w_max_en;
    logic                        w_min_en;

    assign w_en      = i_ready || !r_s2_valid;
    assign w_accept  = i_valid && w_en && (r_state == ST_RUN);
    assign w_addr_ok = (i_cfg_addr <= ADDR_WIDTH'(A_MIN));
    assign w_wr_ok   = i_cfg_we && w_addr_ok && (r_state == ST_CFG);
    assign w_wr_err  = i_cfg_we && !w_wr_ok;

    act_seg_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .NSEG       (NSEG),
        .SEG_W      (SEG_W)
    ) u_cmp (
        .i_dat   (i_dat),
        .i_bp    (r_bp),
        .o_seg_c (w_seg)
    );

    // Max clamp has priority when the two ranges overlap
    assign w_max_en = ($signed(i_dat) >= $signed(r_max));
    assign w_min_en = ($signed(i_dat) <= $signed(r_min)) && !w_max_en;

    // Run-control state machine
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_CFG;
        end else begin
            case (r_state)
                ST_CFG:   if (i_start) r_state <= ST_RUN;
                ST_RUN:   if (i_stop) r_state <= ST_DRAIN;
                ST_DRAIN: if (!r_s1_valid && !r_s2_valid) r_state <= ST_CFG;
                default:  r_state <= ST_CFG;
            endcase
        end
    end

    // Configuration tables, writable only while idle in CFG
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                r_coe[k] <= '0;
            end
            r_bp  <= '0;
            r_max <= DATA_WIDTH'(MAX_RST);
            r_min <= DATA_WIDTH'(MIN_RST);
        end else if (w_wr_ok) begin
            for (int k = 0; k < NSEG; k++) begin
                if (i_cfg_addr == ADDR_WIDTH'(COE_BASE + k)) r_coe[k] <= i_cfg_wdata;
            end
            for (int k = 0; k < NBP; k++) begin
                if (i_cfg_addr == ADDR_WIDTH'(A_BP + k)) begin
                    r_bp[k*DATA_WIDTH +: DATA_WIDTH] <= i_cfg_wdata[DATA_WIDTH-1:0];
                end
            end
            if (i_cfg_addr == ADDR_WIDTH'(A_MAX)) r_max <= i_cfg_wdata[DATA_WIDTH-1:0];
            if (i_cfg_addr == ADDR_WIDTH'(A_MIN)) r_min <= i_cfg_wdata[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_wr_err || w_rd_err;
        end
    end

`ifdef ACT_SEG_SEL_READBACK_EN
    logic [COE_W-1:0] w_rdata;
    logic [COE_W-1:0] r_rdata;

    assign w_rd_err = i_cfg_re && !w_addr_ok;

    // Byte-wide entries come back sign-extended to the full word
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (i_cfg_addr == ADDR_WIDTH'(COE_BASE + k)) w_rdata = r_coe[k];
        end
        for (int k = 0; k < NBP; k++) begin
            if (i_cfg_addr == ADDR_WIDTH'(A_BP + k)) begin
                w_rdata = COE_W'($signed(r_bp[k*DATA_WIDTH +: DATA_WIDTH]));
            end
        end
        if (i_cfg_addr == ADDR_WIDTH'(A_MAX)) w_rdata = COE_W'($signed(r_max));
        if (i_cfg_addr == ADDR_WIDTH'(A_MIN)) w_rdata = COE_W'($signed(r_min));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_cfg_re) begin
            r_rdata <= w_addr_ok ? w_rdata : '0;
        end
    end

    assign o_cfg_rdata = r_rdata;
`else
    assign w_rd_err = 1'b0;
`endif

    // Two-stage pipeline sharing one global enable so stalls freeze both stages together
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_dat    <= '0;
            r_s1_seg    <= '0;
            r_s1_max_en <= 1'b0;
            r_s1_min_en <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_dat    <= '0;
            r_s2_coe    <= '0;
            r_s2_max_en <= 1'b0;
            r_s2_min_en <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= w_accept;
            r_s1_dat    <= i_dat;
            r_s1_seg    <= w_seg;
            r_s1_max_en <= w_max_en;
            r_s1_min_en <= w_min_en;
            r_s2_valid  <= r_s1_valid;
            r_s2_dat    <= r_s1_dat;
            r_s2_coe    <= r_coe[r_s1_seg];
            r_s2_max_en <= r_s1_max_en;
            r_s2_min_en <= r_s1_min_en;
        end
    end

    assign o_in_ready     = w_en && (r_state == ST_RUN);
    assign o_valid        = r_s2_valid;
    assign o_dat          = r_s2_dat;
    assign o_act_coe      = r_s2_coe;
    assign o_max_value_en = r_s2_max_en;
    assign o_min_value_en = r_s2_min_en;
    assign o_max_value    = r_max;
    assign o_min_value    = r_min;
    assign o_cfg_err      = r_cfg_err;
    assign o_state        = r_state;

endmodule

// File: tb/tb_act_seg_sel.sv
// Scoreboard bench for act_seg_sel: driver pushes model results, negedge monitor pops and compares.
module tb_act_seg_sel;

    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 24;
    localparam int unsigned AW   = 5;
    localparam int unsigned NSEG = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0, i_stop = 1'b0;
    logic          i_cfg_we = 1'b0;
    logic [AW-1:0] i_cfg_addr = '0;
    logic [CW-1:0] i_cfg_wdata = '0;
    logic          o_cfg_err;
    logic          i_valid = 1'b0;
    logic          o_in_ready;
    logic [DW-1:0] i_dat = '0;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic [DW-1:0] o_dat;
    logic [CW-1:0] o_act_coe;
    logic          o_max_value_en, o_min_value_en;
    logic [DW-1:0] o_max_value, o_min_value;
    logic [1:0]    o_state;
`ifdef ACT_SEG_SEL_READBACK_EN
    logic          i_cfg_re = 1'b0;
    logic [CW-1:0] o_cfg_rdata;
`endif

    act_seg_sel dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_cfg_we       (i_cfg_we),
        .i_cfg_addr     (i_cfg_addr),
        .i_cfg_wdata    (i_cfg_wdata),
        .o_cfg_err      (o_cfg_err),
`ifdef ACT_SEG_SEL_READBACK_EN
        .i_cfg_re       (i_cfg_re),
        .o_cfg_rdata    (o_cfg_rdata),
`endif
        .i_valid        (i_valid),
        .o_in_ready     (o_in_ready),
        .i_dat          (i_dat),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_dat          (o_dat),
        .o_act_coe      (o_act_coe),
        .o_max_value_en (o_max_value_en),
        .o_min_value_en (o_min_value_en),
        .o_max_value    (o_max_value),
        .o_min_value    (o_min_value),
        .o_state        (o_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [CW-1:0] coe;
        logic          mxen;
        logic          mnen;
        logic [DW-1:0] mxv;
        logic [DW-1:0] mnv;
    } out_t;

    typedef struct {
        out_t o;
        int   cyc;
        bit   lat_chk;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            rdy_mode = 0;
    int            rdy_ph = 0;
    int            st_m = 0;
    int            bp_m[NSEG-1];
    logic [CW-1:0] coe_m[NSEG];
    int            max_m, min_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void reset_model();
        for (int k = 0; k < NSEG - 1; k++) bp_m[k] = 0;
        for (int k = 0; k < NSEG; k++) coe_m[k] = '0;
        max_m = 127;
        min_m = -128;
        st_m  = 0;
    endfunction

    // Reference: segment = how many breakpoints the sample reaches; max clamp beats min clamp
    function automatic out_t model(input logic [DW-1:0] x);
        out_t r;
        int   xs;
        int   seg;
        xs  = int'($signed(x));
        seg = 0;
        for (int k = 0; k < NSEG - 1; k++) if (xs >= bp_m[k]) seg++;
        r.dat  = x;
        r.coe  = coe_m[seg];
        r.mxen = (xs >= max_m);
        r.mnen = (xs <= min_m) && !r.mxen;
        r.mxv  = DW'(max_m);
        r.mnv  = DW'(min_m);
        return r;
    endfunction

    // Downstream ready pattern generator
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: i_ready = 1'b1;
            1: i_ready = 1'($urandom_range(0, 1));
            2: begin
                i_ready = (rdy_ph == 0);
                rdy_ph  = (rdy_ph + 1) % 3;
            end
            default: i_ready = 1'b0;
        endcase
    end

    // Monitor: pop on each transfer, and insist a stalled output holds still
    out_t mon_cur, mon_held;
    exp_t mon_e;
    bit   mon_held_v = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_held_v = 0;
        end else begin
            mon_cur = '{dat: o_dat, coe: o_act_coe, mxen: o_max_value_en, mnen: o_min_value_en,
                        mxv: o_max_value, mnv: o_min_value};
            if (mon_held_v) check("stall_hold", 64'({o_valid, mon_cur}), 64'({1'b1, mon_held}));
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_out: got dat %0h with nothing expected", o_dat);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_fields", 64'(mon_cur), 64'(mon_e.o));
                    if (mon_e.lat_chk) check("latency", 64'(cyc - mon_e.cyc), 64'(2));
                end
            end
            mon_held_v = o_valid && !i_ready;
            mon_held   = mon_cur;
        end
    end

    // All main-flow tasks begin and end 1 time unit after a rising edge
    task automatic send(input logic [DW-1:0] x);
        bit   done;
        exp_t e;
        done    = 0;
        i_valid = 1'b1;
        i_dat   = x;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (o_in_ready) begin
                e.o       = model(x);
                e.cyc     = cyc;
                e.lat_chk = (rdy_mode == 0);
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: sample %0h never accepted", x);
        end
    endtask

    task automatic cfg_write(input int addr, input logic [CW-1:0] data);
        bit err;
        err         = (st_m != 0) || (addr > 2 * NSEG);
        i_cfg_we    = 1'b1;
        i_cfg_addr  = AW'(addr);
        i_cfg_wdata = data;
        @(posedge clk);
        #1;
        i_cfg_we = 1'b0;
        check("cfg_err", 64'(o_cfg_err), 64'(err));
        if (!err) begin
            if (addr < NSEG) coe_m[addr] = data;
            else if (addr < 2 * NSEG - 1) bp_m[addr - NSEG] = int'($signed(data[DW-1:0]));
            else if (addr == 2 * NSEG - 1) max_m = int'($signed(data[DW-1:0]));
            else min_m = int'($signed(data[DW-1:0]));
        end
    endtask

    task automatic pulse(input bit s, input bit p);
        i_start = s;
        i_stop  = p;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_stop  = 1'b0;
        if (st_m == 0 && s) st_m = 1;
        else if (st_m == 1 && p) st_m = 2;
        check("state_after_pulse", 64'(o_state), 64'(st_m));
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            if (sb.size() == 0 && o_state == 2'd0) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        st_m = 0;
        check("drain_to_cfg", 64'({done, o_state}), 64'({1'b1, 2'd0}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_state", 64'(o_state), 64'(0));
        check("rst_valid", 64'({o_valid, o_in_ready, o_cfg_err}), 64'(0));
        check("rst_fields", 64'({o_dat, o_act_coe, o_max_value_en, o_min_value_en}), 64'(0));
        check("rst_clamps", 64'({o_max_value, o_min_value}), 64'(16'h7F80));

        // Default tables: single sample
        rdy_mode = 0;
        pulse(1, 0);
        send(8'd5);
        pulse(0, 1);
        wait_drain();

        // Breakpoint table and per-segment coefficients
        for (int k = 0; k < NSEG; k++) cfg_write(k, {8'(k), 16'(k * 100)});
        begin
            int bps[7] = '{-64, -32, 0, 16, 32, 64, 96};
            for (int k = 0; k < NSEG - 1; k++) cfg_write(NSEG + k, CW'(bps[k]));
        end
`ifdef ACT_SEG_SEL_READBACK_EN
        i_cfg_re   = 1'b1;
        i_cfg_addr = AW'(NSEG);
        @(posedge clk);
        #1;
        i_cfg_re = 1'b0;
        check("readback_bp0", 64'(o_cfg_rdata), 64'(24'hFFFFC0));
`endif
        pulse(1, 0);
        send(8'hC0);
        send(8'hFF);
        send(8'h00);
        send(8'd100);
        cfg_write(0, 24'hABCDEF);
        send(8'h9C);
        pulse(0, 1);
        wait_drain();

        // Clamp boundaries, start and stop together in each state
        cfg_write(2 * NSEG - 1, 24'd50);
        cfg_write(2 * NSEG, 24'hFFFFCE);
        pulse(1, 1);
        send(8'd50);
        send(8'hCE);
        send(8'd49);
        pulse(1, 1);
        wait_drain();

        // Overlapping clamps
        cfg_write(2 * NSEG - 1, 24'hFFFFF6);
        cfg_write(2 * NSEG, 24'd10);
        pulse(1, 0);
        send(8'd0);
        send(8'd10);
        send(8'hF5);
        pulse(0, 1);
        wait_drain();

        // Stall pattern 1,0,0 on downstream ready
        rdy_mode = 2;
        pulse(1, 0);
        for (int i = 0; i < 8; i++) send(8'($urandom));
        pulse(0, 1);
        wait_drain();

        // Stop with two samples in flight while downstream is blocked
        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        pulse(1, 0);
        send(8'd20);
        send(8'hE0);
        pulse(0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("held_in_drain", 64'({o_state, o_valid}), 64'({2'd2, 1'b1}));
        rdy_mode = 0;
        wait_drain();

        // Random tables, random ready
        for (int k = 0; k <= 2 * NSEG; k++) cfg_write(k, CW'($urandom));
        rdy_mode = 1;
        pulse(1, 0);
        for (int i = 0; i < 40; i++) send(8'($urandom));
        pulse(0, 1);
        rdy_mode = 0;
        wait_drain();

        // Out-of-range config addresses
        cfg_write(2 * NSEG + 1, 24'h123456);
        cfg_write(31, 24'h654321);
        cfg_write(2 * NSEG, 24'h000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
